// File: rtl/branch_resolve_ctrl_if.sv
// Signal bundle between the pipeline (IF/EX/comparator) and branch_resolve_ctrl.
// Names carry the block's own _i/_o direction so that they line up with its ports.
interface branch_resolve_ctrl_if #(parameter int XLEN = 32);
  logic [XLEN-1:0] if_pc_i;
  logic            if_pred_taken_o;
  logic            ex_valid_i;
  logic            ex_branch_i;
  logic            ex_jump_i;
  logic [2:0]      ex_funct3_i;
  logic [XLEN-1:0] ex_pc_i;
  logic [XLEN-1:0] ex_target_i;
  logic            ex_pred_taken_i;
  logic            stall_i;
  logic            BrUn_o;
  logic            BrEq_i;
  logic            BrLt_i;
  logic            redirect_o;
  logic [XLEN-1:0] redirect_pc_o;
  logic            flush_o;

  modport slave (
    input  if_pc_i, ex_valid_i, ex_branch_i, ex_jump_i, ex_funct3_i, ex_pc_i,
           ex_target_i, ex_pred_taken_i, stall_i, BrEq_i, BrLt_i,
    output if_pred_taken_o, BrUn_o, redirect_o, redirect_pc_o, flush_o
  );

  modport master (
    output if_pc_i, ex_valid_i, ex_branch_i, ex_jump_i, ex_funct3_i, ex_pc_i,
           ex_target_i, ex_pred_taken_i, stall_i, BrEq_i, BrLt_i,
    input  if_pred_taken_o, BrUn_o, redirect_o, redirect_pc_o, flush_o
  );
endinterface

// File: rtl/branch_resolve_ctrl.sv
// EX-stage branch resolution, mispredict redirect/flush and 2-bit BHT.
// Optional BRANCH_PERF_CNT_EN adds branch and mispredict counters.
module branch_resolve_ctrl #(
  parameter int XLEN      = 32,
  parameter int BHT_IDX_W = 6
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  branch_resolve_ctrl_if.slave bus
`ifdef BRANCH_PERF_CNT_EN
  ,
  output logic [31:0]          branch_cnt_o,
  output logic [31:0]          mispred_cnt_o
`endif
);
  localparam int BHT_N = 1 << BHT_IDX_W;

  logic [1:0]           bht [BHT_N];
  logic [BHT_IDX_W-1:0] if_idx, ex_idx;
  logic                 legal, br_taken, taken, resolve, do_redirect, bht_upd;
  logic [XLEN-1:0]      next_pc;
  logic                 redirect_q, flush_q;
  logic [XLEN-1:0]      redirect_pc_q;
  logic                 unused_pc_bits;

  assign if_idx = bus.if_pc_i[BHT_IDX_W+1:2];
  assign ex_idx = bus.ex_pc_i[BHT_IDX_W+1:2];
  assign unused_pc_bits = ^{bus.if_pc_i[XLEN-1:BHT_IDX_W+2], bus.if_pc_i[1:0]};

  assign bus.if_pred_taken_o = bht[if_idx][1];
  assign bus.BrUn_o          = bus.ex_funct3_i[1];

  always_comb begin
    legal    = 1'b1;
    br_taken = 1'b0;
    case (bus.ex_funct3_i)
      3'b000:         br_taken = bus.BrEq_i;
      3'b001:         br_taken = ~bus.BrEq_i;
      3'b100, 3'b110: br_taken = bus.BrLt_i;
      3'b101, 3'b111: br_taken = ~bus.BrLt_i;
      default:        legal    = 1'b0;
    endcase
  end

  // The instruction behind an active redirect is wrong-path, hence the mask.
  assign resolve     = bus.ex_valid_i & ~bus.stall_i & ~redirect_q &
                       (bus.ex_branch_i | bus.ex_jump_i);
  assign taken       = bus.ex_jump_i | (legal & br_taken);
  assign do_redirect = resolve & (bus.ex_jump_i | (taken != bus.ex_pred_taken_i));
  assign next_pc     = taken ? bus.ex_target_i : bus.ex_pc_i + XLEN'(4);
  assign bht_upd     = resolve & bus.ex_branch_i & ~bus.ex_jump_i & legal;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      redirect_q    <= 1'b0;
      flush_q       <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      redirect_q <= do_redirect;
      flush_q    <= do_redirect;
      if (do_redirect) redirect_pc_q <= next_pc;
    end
  end

  assign bus.redirect_o    = redirect_q;
  assign bus.flush_o       = flush_q;
  assign bus.redirect_pc_o = redirect_pc_q;

  // Saturating 2-bit counters; lookup sees the pre-update value.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < BHT_N; i++) bht[i] <= 2'b01;
    end else if (bht_upd) begin
      if (br_taken && bht[ex_idx] != 2'b11)
        bht[ex_idx] <= bht[ex_idx] + 2'd1;
      else if (!br_taken && bht[ex_idx] != 2'b00)
        bht[ex_idx] <= bht[ex_idx] - 2'd1;
    end
  end

`ifdef BRANCH_PERF_CNT_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      branch_cnt_o  <= '0;
      mispred_cnt_o <= '0;
    end else begin
      if (resolve && bus.ex_branch_i) branch_cnt_o <= branch_cnt_o + 32'd1;
      if (do_redirect)                mispred_cnt_o <= mispred_cnt_o + 32'd1;
    end
  end
`endif
endmodule

// File: doc/branch_resolve_ctrl.md
Name: branch_resolve_ctrl

Overview:
- EX-stage consumer of the branch comparator outputs (BrEq/BrLt).
- Decodes funct3 into BrUn for the comparator and resolves taken/not-taken for conditional branches and jumps.
- Checks the outcome against the prediction carried down the pipe; on a mismatch, issues a registered PC redirect and a one-cycle flush of IF/ID and ID/EX.
- Owns a 2-bit saturating-counter branch history table (BHT); the IF stage looks up predictions in it and EX updates it.

Parameters:
- XLEN, 32, data/PC width.
- BHT_IDX_W, 6, BHT index width; the table has 2^BHT_IDX_W entries.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous reset, active-high.
- if_pc_i  in  XLEN  IF-stage PC used for BHT lookup.
- if_pred_taken_o  out  1  prediction for if_pc_i; combinational, counter MSB.
- ex_valid_i  in  1  EX stage holds a valid instruction.
- ex_branch_i  in  1  EX instruction is a conditional branch.
- ex_jump_i  in  1  EX instruction is JAL/JALR.
- ex_funct3_i  in  3  funct3 field of the EX instruction.
- ex_pc_i  in  XLEN  PC of the EX instruction.
- ex_target_i  in  XLEN  branch/jump target computed in EX.
- ex_pred_taken_i  in  1  prediction made in IF, carried to EX.
- stall_i  in  1  pipeline stall; EX contents are held.
- BrUn_o  out  1  unsigned-compare select to the comparator; equals ex_funct3_i[1], combinational.
- BrEq_i  in  1  comparator equal result.
- BrLt_i  in  1  comparator less-than result.
- redirect_o  out  1  registered one-cycle PC redirect strobe.
- redirect_pc_o  out  XLEN  registered redirect PC.
- flush_o  out  1  registered one-cycle flush of IF/ID and ID/EX.

Behaviour:
- Reset (async, rst_i=1):
  - redirect_o=0, redirect_pc_o=0, flush_o=0.
  - All BHT counters are set to 2'b01 (weakly not-taken).
  - Takes effect immediately, including mid-redirect; a pending strobe is dropped.
- resolve = ex_valid_i & ~stall_i & ~redirect_o & (ex_branch_i | ex_jump_i).
  - While redirect_o=1, the instruction in EX is wrong-path. It is ignored: no redirect and no BHT update.
- Taken decode for conditional branches, by funct3:
  - 000 → BrEq_i
  - 001 → ~BrEq_i
  - 100 and 110 → BrLt_i
  - 101 and 111 → ~BrLt_i
  - 010 and 011 are illegal: not taken, no BHT update.
- Jumps are always taken; ex_pred_taken_i is ignored for jumps and a jump always redirects to ex_target_i.
- Branch mispredict = taken != ex_pred_taken_i.
  - taken & ~pred → redirect to ex_target_i.
  - ~taken & pred → redirect to ex_pc_i + 4, modulo 2^XLEN (wrap-around allowed).
  - A correct prediction produces no redirect.
- Latency: resolution is combinational in cycle N. At the rising edge ending N, redirect_o and flush_o go to 1 with redirect_pc_o loaded. At the next edge both return to 0, regardless of stall_i.
  - redirect_pc_o holds its last value when redirect_o=0.
- Back-to-back: a redirect cannot be issued in consecutive cycles, because of the redirect_o mask.
- BHT index = PC[BHT_IDX_W+1:2].
  - Lookup is combinational from if_pc_i.
  - Update happens at the edge ending a resolve cycle, only for a conditional branch with legal funct3:
    - taken → saturating increment (11 stays 11).
    - not taken → saturating decrement (00 stays 00).
  - Read-during-write to the same index returns the pre-update value; there is no bypass.
- Stall: with stall_i=1, the BHT, redirect_pc_o and all state are unchanged, except that an active redirect_o/flush_o still deasserts.

Optional Feature:
- Macro: BRANCH_PERF_CNT_EN.
- With the macro defined, two extra ports are added:
  - branch_cnt_o  out  32  increments on every resolve cycle with ex_branch_i=1.
  - mispred_cnt_o  out  32  increments on every redirect issued.
  - Both reset to 0 and wrap at 2^32.
- Without the macro: neither port nor the counters exist, and behaviour is otherwise identical.

Test Plan:
- Reset, then read if_pc_i=0x100 → if_pred_taken_o=0; all indices read counter 01.
- BEQ at ex_pc_i=0x40, BrEq_i=1, pred=0, target=0x80 → next cycle redirect_o=1, flush_o=1, redirect_pc_o=0x80; the BHT[16] counter becomes 10; lookup at 0x40 gives pred=1; both strobes return to 0 one cycle later.
- BGEU, funct3=111, BrLt_i=0, pred=1 → no redirect; BrUn_o=1; the counter saturates 10→11→11 over two repeats.
- BNE at ex_pc_i=0xFFFFFFFC, BrEq_i=1, pred=1 → redirect_pc_o=0x00000000; counter decrements.
- JAL immediately followed by a valid BLT that would mispredict → only the JAL redirect is issued; the BLT is ignored with no BHT change; stall_i=1 during a mispredicting branch gives no redirect until stall_i=0.
- Assert rst_i mid-cycle while redirect_o=1 → redirect_o and flush_o drop to 0 immediately; the BHT returns to 01.
  - With BRANCH_PERF_CNT_EN defined, the counters also read 0 after this reset, and the earlier scenarios are checked to produce the expected counts.
